// File: rtl/csa_pipe_adder.sv
// -----------------------------------------------------------------------------
// csa_pipe_adder
//
// Pipelined carry-select adder/subtractor. The operand is split into
// NBLK = WIDTH/BLK_W blocks. Each block is resolved in its own pipeline
// stage, so one operation can be accepted per cycle.
//
// Each block computes its sum for carry-in 0 and for carry-in 1, then picks
// one with the carry arriving from the stage before. Bits that are already
// resolved are only copied forward, never recomputed.
//
// Ports
//   clk          in   rising-edge clock
//   rst_n        in   synchronous active-low reset
//   in_valid     in   operands/mode valid
//   in_ready     out  block can accept this cycle
//   i_add_term1  in   operand A [WIDTH]
//   i_add_term2  in   operand B [WIDTH]
//   i_cin        in   carry-in (ignored when i_sub=1)
//   i_sub        in   1: A - B, 0: A + B + i_cin
//   out_valid    out  result valid
//   out_ready    in   downstream accepts the result
//   sum          out  result modulo 2^WIDTH
//   cout         out  carry-out of MSB (subtract: 1 = no borrow)
//   ovf          out  signed two's-complement overflow
//
// Handshake: an input transfer happens on a rising edge where
// in_valid && in_ready. An output transfer happens on a rising edge where
// out_valid && out_ready. stall = out_valid && !out_ready, and
// in_ready = !stall. During a stall every stage holds, including bubbles.
// Otherwise every stage advances each cycle. A stage that receives no valid
// data loads valid=0 and don't-care data. While out_valid=1 and out_ready=0,
// the result stays stable.
// -----------------------------------------------------------------------------
module csa_pipe_adder #(
    parameter int WIDTH = 16,
    parameter int BLK_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] i_add_term1,
    input  logic [WIDTH-1:0] i_add_term2,
    input  logic             i_cin,
    input  logic             i_sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int NBLK = WIDTH / BLK_W;

    generate
        if ((BLK_W < 1) || (BLK_W > WIDTH) || ((WIDTH % BLK_W) != 0)) begin : g_param_check
            $error("csa_pipe_adder: WIDTH must be a positive multiple of BLK_W");
        end
    endgenerate

    // ------------------------------------------------------------------
    // Stage registers. Index s holds the state of stage S_{s+1}:
    //   r_sum[s] bits of blocks 0..s are resolved; higher bits are unused.
    //   r_c[s]   is the carry into block s+1 (the final carry for the last stage).
    //   r_a/r_b  carry the A/B' slices forward. Only the slices of blocks
    //            above s are still consumed.
    // ------------------------------------------------------------------
    logic             r_vld [NBLK];
    logic [WIDTH-1:0] r_sum [NBLK];
    logic [WIDTH-1:0] r_a   [NBLK];
    logic [WIDTH-1:0] r_b   [NBLK];
    logic             r_c   [NBLK];
    logic             r_cmsb;           // carry into the MSB, last stage only

    // Inputs seen by each stage's block (operand port for stage 0,
    // previous stage register otherwise).
    logic             w_src_vld [NBLK];
    logic [WIDTH-1:0] w_src_sum [NBLK];
    logic [WIDTH-1:0] w_src_a   [NBLK];
    logic [WIDTH-1:0] w_src_b   [NBLK];
    logic             w_src_c   [NBLK];

    // Carry-select candidates and selected result per block: {carry, sum}.
    logic [BLK_W:0]   w_r0  [NBLK];
    logic [BLK_W:0]   w_r1  [NBLK];
    logic [BLK_W:0]   w_sel [NBLK];
    logic [WIDTH-1:0] w_nsum [NBLK];
    logic             w_ncmsb;
    logic             w_stall;

    assign w_stall  = r_vld[NBLK-1] && !out_ready;
    assign in_ready = !w_stall;

    always_comb begin
        // Stage 0 consumes the operand ports. Subtraction is A + ~B + 1.
        w_src_vld[0] = in_valid;
        w_src_sum[0] = '0;
        w_src_a[0]   = i_add_term1;
        w_src_b[0]   = i_sub ? ~i_add_term2 : i_add_term2;
        w_src_c[0]   = i_sub | i_cin;

        for (int s = 1; s < NBLK; s++) begin
            w_src_vld[s] = r_vld[s-1];
            w_src_sum[s] = r_sum[s-1];
            w_src_a[s]   = r_a[s-1];
            w_src_b[s]   = r_b[s-1];
            w_src_c[s]   = r_c[s-1];
        end

        for (int s = 0; s < NBLK; s++) begin
            w_r0[s] = {1'b0, w_src_a[s][s*BLK_W +: BLK_W]}
                    + {1'b0, w_src_b[s][s*BLK_W +: BLK_W]};
            w_r1[s] = {1'b0, w_src_a[s][s*BLK_W +: BLK_W]}
                    + {1'b0, w_src_b[s][s*BLK_W +: BLK_W]}
                    + {{BLK_W{1'b0}}, 1'b1};
            w_sel[s] = w_src_c[s] ? w_r1[s] : w_r0[s];

            w_nsum[s] = w_src_sum[s];
            w_nsum[s][s*BLK_W +: BLK_W] = w_sel[s][BLK_W-1:0];
        end

        // The MSB sum bit is a ^ b ^ carry_in, so the carry into the MSB
        // can be recovered from the selected sum bit of the last block.
        w_ncmsb = w_sel[NBLK-1][BLK_W-1]
                ^ w_src_a[NBLK-1][WIDTH-1]
                ^ w_src_b[NBLK-1][WIDTH-1];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int s = 0; s < NBLK; s++) begin
                r_vld[s] <= 1'b0;
                r_sum[s] <= '0;
                r_a[s]   <= '0;
                r_b[s]   <= '0;
                r_c[s]   <= 1'b0;
            end
            r_cmsb <= 1'b0;
        end else if (!w_stall) begin
            for (int s = 0; s < NBLK; s++) begin
                r_vld[s] <= w_src_vld[s];
                r_sum[s] <= w_nsum[s];
                r_a[s]   <= w_src_a[s];
                r_b[s]   <= w_src_b[s];
                r_c[s]   <= w_sel[s][BLK_W];
            end
            r_cmsb <= w_ncmsb;
        end
    end

    assign out_valid = r_vld[NBLK-1];
    assign sum       = r_sum[NBLK-1];
    assign cout      = r_c[NBLK-1];
    assign ovf       = r_cmsb ^ r_c[NBLK-1];

endmodule

// File: tb/tb_csa_pipe_adder.sv
module tb_csa_pipe_adder;
  localparam int WIDTH = 16;
  localparam int BLK_W = 4;
  localparam int NBLK  = WIDTH / BLK_W;
  localparam int W     = WIDTH + 2;   // {ovf, cout, sum}

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_valid = 1'b0;
  logic in_ready;
  logic [WIDTH-1:0] i_add_term1 = '0;
  logic [WIDTH-1:0] i_add_term2 = '0;
  logic i_cin = 1'b0;
  logic i_sub = 1'b0;
  logic out_valid;
  logic out_ready = 1'b1;
  logic [WIDTH-1:0] sum;
  logic cout;
  logic ovf;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  csa_pipe_adder #(.WIDTH(WIDTH), .BLK_W(BLK_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .i_add_term1(i_add_term1), .i_add_term2(i_add_term2),
    .i_cin(i_cin), .i_sub(i_sub),
    .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .ovf(ovf)
  );

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached (got running, required finished)");
    $fatal(1, "watchdog");
  end

  // ---------------- checking ----------------
  int n_cmp = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h required 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: integer arithmetic on the whole word, with signed
  // overflow taken from the range of the true signed result.
  function automatic logic [W-1:0] model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                         input logic cin, input logic sub);
    logic [WIDTH-1:0] bp;
    logic c;
    longint tot;
    longint sa;
    longint sb;
    longint r;
    longint lim;
    logic o;
    bp  = sub ? ~b : b;
    c   = sub ? 1'b1 : cin;
    tot = longint'(a) + longint'(bp) + longint'(c);
    sa  = longint'($signed(a));
    sb  = longint'($signed(bp));
    r   = sa + sb + longint'(c);
    lim = longint'(1) << (WIDTH - 1);
    o   = (r >= lim) || (r < -lim);
    return {o, tot[WIDTH], tot[WIDTH-1:0]};
  endfunction

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  int out_cyc_q[$];
  bit sb_en = 1'b0;
  bit prev_stall = 1'b0;
  logic [W-1:0] held;
  int n_stall_seen = 0;

  always @(negedge clk) begin
    logic [W-1:0] e;
    if (sb_en && rst_n) begin
      if (prev_stall) begin
        chk("hold_valid", {31'b0, out_valid}, 32'd1);
        chk("hold_data", {14'b0, ovf, cout, sum}, {14'b0, held});
      end
      if (out_valid && !out_ready) begin
        n_stall_seen++;
        chk("stall_in_ready", {31'b0, in_ready}, 32'd0);
      end
      if (in_valid && in_ready)
        exp_q.push_back(model(i_add_term1, i_add_term2, i_cin, i_sub));
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL unexpected_output: got sum 0x%0h, required no output", sum);
        end else begin
          e = exp_q.pop_front();
          chk("stream_result", {14'b0, ovf, cout, sum}, {14'b0, e});
          out_cyc_q.push_back(cyc);
        end
      end
      prev_stall = out_valid && !out_ready;
      held = {ovf, cout, sum};
    end else begin
      prev_stall = 1'b0;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive_rand();
    i_add_term1 = WIDTH'($urandom);
    i_add_term2 = WIDTH'($urandom);
    i_cin = 1'($urandom_range(0, 1));
    i_sub = 1'($urandom_range(0, 1));
  endtask

  // One isolated operation. lat counts the edges from the accept edge
  // (inclusive) to the first sample with out_valid=1.
  task automatic send_one(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                          input logic cin, input logic sub,
                          output int lat, output logic [W-1:0] res);
    @(posedge clk); #1;
    i_add_term1 = a; i_add_term2 = b; i_cin = cin; i_sub = sub; in_valid = 1'b1;
    @(negedge clk);
    chk("accept_ready", {31'b0, in_ready}, 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    drive_rand();
    lat = 1;
    res = '0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (out_valid) begin
        res = {ovf, cout, sum};
        break;
      end
      @(posedge clk);
      lat++;
    end
  endtask

  task automatic wait_drain(input string name);
    for (int k = 0; k < 60 && exp_q.size() != 0; k++) @(posedge clk);
    @(negedge clk);
    chk(name, exp_q.size(), 32'd0);
  endtask

  // ---------------- directed vectors ----------------
  typedef struct {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic cin;
    logic sub;
    logic [WIDTH-1:0] s;
    logic co;
    logic ov;
  } vec_t;

  vec_t vecs[10];

  initial begin
    int lat;
    logic [W-1:0] res;
    int seen;
    int sent;
    bit pending;

    //           a         b         cin   sub   sum       cout  ovf
    vecs[0] = '{16'h1234, 16'h0FFF, 1'b0, 1'b0, 16'h2233, 1'b0, 1'b0};
    vecs[1] = '{16'hFFFF, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0};
    vecs[2] = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1};
    vecs[3] = '{16'h0003, 16'h0005, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0};
    vecs[4] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
    vecs[5] = '{16'h0005, 16'h0003, 1'b0, 1'b1, 16'h0002, 1'b1, 1'b0};
    vecs[6] = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1};
    vecs[7] = '{16'h0010, 16'h0001, 1'b1, 1'b1, 16'h000F, 1'b1, 1'b0};
    vecs[8] = '{16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 16'hFFFF, 1'b1, 1'b0};
    vecs[9] = '{16'h00FF, 16'h0000, 1'b1, 1'b0, 16'h0100, 1'b0, 1'b0};

    // Reset held for 3 edges with in_valid=1 and random data.
    rst_n = 1'b0;
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      drive_rand();
      @(negedge clk);
      chk("reset_outputs", {13'b0, out_valid, cout, ovf, sum}, 32'd0);
    end
    rst_n = 1'b1;
    in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("ready_after_reset", {31'b0, in_ready}, 32'd1);
    chk("idle_after_reset", {13'b0, out_valid, cout, ovf, sum}, 32'd0);

    // Directed table: latency and exact result of each vector.
    for (int i = 0; i < 10; i++) begin
      send_one(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sub, lat, res);
      chk($sformatf("vec%0d_latency", i), lat, NBLK);
      chk($sformatf("vec%0d_result", i), {14'b0, res},
          {14'b0, vecs[i].ov, vecs[i].co, vecs[i].s});
    end
    @(posedge clk);

    // Back-to-back: 8 random ops, out_ready held high.
    sb_en = 1'b1;
    out_cyc_q.delete();
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      drive_rand();
      in_valid = 1'b1;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    wait_drain("b2b_drain");
    chk("b2b_count", out_cyc_q.size(), 32'd8);
    if (out_cyc_q.size() == 8)
      chk("b2b_consecutive", out_cyc_q[7] - out_cyc_q[0], 32'd7);

    // Backpressure: random stream with a 3-cycle out_ready drop mid-stream.
    n_stall_seen = 0;
    sent = 0;
    pending = 1'b0;
    for (int step = 0; step < 300 && sent < 24; step++) begin
      @(posedge clk); #1;
      if (!pending) begin
        drive_rand();
        in_valid = (step < 14) ? 1'b1 : 1'($urandom_range(0, 3) != 0);
        pending = in_valid;
      end
      out_ready = !(step >= 8 && step < 11);
      @(negedge clk);
      if (in_valid && in_ready) begin
        sent++;
        pending = 1'b0;
      end
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    chk("bp_all_sent", sent, 32'd24);
    wait_drain("bp_drain");
    chk("bp_stall_cycles", n_stall_seen, 32'd3);

    // Reset mid-flight: two ops accepted, reset before either completes.
    sb_en = 1'b0;
    @(posedge clk); #1;
    i_add_term1 = 16'h1111; i_add_term2 = 16'h2222; i_cin = 1'b0; i_sub = 1'b0;
    in_valid = 1'b1;
    @(posedge clk); #1;
    i_add_term1 = 16'h3333; i_add_term2 = 16'h0001; i_sub = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    seen = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (out_valid) seen++;
      @(posedge clk);
    end
    chk("flush_no_output", seen, 32'd0);
    send_one(16'h1234, 16'h0FFF, 1'b0, 1'b0, lat, res);
    chk("post_reset_latency", lat, NBLK);
    chk("post_reset_result", {14'b0, res}, {14'b0, model(16'h1234, 16'h0FFF, 1'b0, 1'b0)});
    @(posedge clk);

    // Extra random stream with random backpressure.
    sb_en = 1'b1;
    sent = 0;
    pending = 1'b0;
    for (int step = 0; step < 400 && sent < 40; step++) begin
      @(posedge clk); #1;
      if (!pending) begin
        drive_rand();
        in_valid = 1'($urandom_range(0, 3) != 0);
        pending = in_valid;
      end
      out_ready = 1'($urandom_range(0, 2) != 0);
      @(negedge clk);
      if (in_valid && in_ready) begin
        sent++;
        pending = 1'b0;
      end
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    chk("rand_all_sent", sent, 32'd40);
    wait_drain("rand_drain");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
